dcache_miss_handler: RTL and testbench
======================================

# dcache_miss_handler

Memory-side miss/write engine for the data cache. Accepts one miss or write request at a time from the cache, performs a single-word read or write-through transaction to backing memory over a req/ack handshake, and returns a one-cycle refill beat (index, tag, data, error) for the cache to install. Sits between the dcache and the memory bus arbiter, with one outstanding transaction at a time.

## Interface
- `TIMEOUT_CYCLES`, default 64: cycles `mem_req` may stay unacknowledged before the transaction is aborted with an error (must be ≥1).
- `CNT_WIDTH`, default 16: width of the saturating statistics counters.

Ports:
- `clk` in 1: single clock; all logic is on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `miss_valid` in 1: cache presents a request.
- `miss_ready` out 1: handler can accept a request; high only in IDLE.
- `miss_addr` in 32: request byte address.
- `miss_we` in 1: 1 = write (write-through plus write-allocate), 0 = read refill.
- `miss_wdata` in 32: write data; ignored when `miss_we` = 0.
- `fill_valid` out 1: one-cycle refill beat.
- `fill_index` out 4: equals `addr[3:0]` of the serviced request.
- `fill_tag` out 28: equals `addr[31:4]` of the serviced request.
- `fill_data` out 32: read data, or write data for writes; 0 on error.
- `fill_err` out 1: qualifies `fill_valid`; set on memory error or timeout.
- `mem_req` out 1: memory request.
- `mem_we` out 1: memory write.
- `mem_addr` out 32: memory address.
- `mem_wdata` out 32: memory write data.
- `mem_ack` in 1: memory completion.
- `mem_rdata` in 32: read data, valid when `mem_ack` = 1.
- `mem_err` in 1: error flag, valid when `mem_ack` = 1.
- `busy` out 1: high whenever the state is not IDLE.
- `miss_count` out CNT_WIDTH: accepted requests; saturates at all-ones.
- `err_count` out CNT_WIDTH: error or timeout completions; saturates.

## Operation
- FSM states: IDLE, REQ, RESP.
- **IDLE**
  - `miss_ready` = 1.
  - On `miss_valid` = 1: capture `miss_addr`, `miss_we` and `miss_wdata`; clear the timeout counter; increment `miss_count`; go to REQ.
- **REQ**
  - `mem_req` = 1, with `mem_addr`, `mem_we` and `mem_wdata` driven from the captured registers and held stable.
  - On `mem_ack` = 1: latch the result and go to RESP.
    - Read with `mem_err` = 0: result data = `mem_rdata`.
    - Write with `mem_err` = 0: result data = captured wdata.
    - `mem_err` = 1: data = 0 and err = 1.
  - Otherwise increment the timeout counter. When the count reaches `TIMEOUT_CYCLES` with no ack: drop `mem_req`, set err = 1, data = 0, go to RESP.
- **RESP**
  - `fill_valid` = 1 for exactly one cycle, with the latched index, tag, data and err.
  - Increment `err_count` if err = 1.
  - Go to IDLE.
- `mem_ack` outside REQ is ignored: no state change and no counter change.
- `miss_valid` outside IDLE is ignored. The cache holds its request until `miss_ready` is high.
- `mem_wdata` = 0 and `mem_we` = 0 whenever `mem_req` = 0.
- On an ack in the same cycle the timeout would expire, the ack wins and the transaction completes normally.
- Counter saturation: at all-ones the counter holds its value; there is no wrap.

## Timing
- Reset (asynchronous on `rst_n` low, effective immediately even mid-transaction):
  - State = IDLE; `miss_ready` = 1.
  - All other outputs = 0, including both counters.
  - Any in-flight transaction is abandoned and no fill beat is issued.
- Request accepted at edge E0 (`miss_valid` & `miss_ready`):
  - `mem_req` is high from E0 to the edge where `mem_ack` is sampled high (Ea ≥ E0 + 1).
  - `fill_valid` is high from Ea to Ea + 1.
  - `miss_ready` is high again at Ea + 1.
- Minimum request-to-fill latency is 2 cycles; back-to-back accepts are at least 3 cycles apart.
- Timeout: with no ack, `mem_req` stays high for exactly `TIMEOUT_CYCLES` cycles, then `fill_valid` is issued with `fill_err` = 1 on the following cycle.

## Test plan
- **Read, immediate ack:** read `miss_addr` = 0x0000_1234, `mem_ack` on the first `mem_req` cycle, `mem_rdata` = 0xDEAD_BEEF. Expect `fill_valid` 2 cycles after accept, `fill_index` = 0x4, `fill_tag` = 0x0000123, `fill_data` = 0xDEAD_BEEF, `fill_err` = 0, `miss_count` = 1.
- **Write, delayed ack:** write 0xCAFE_F00D to 0x8000_0010, ack after 5 cycles. Expect `mem_we` = 1 and `mem_addr`/`mem_wdata` stable for all 5 cycles, `fill_data` = 0xCAFE_F00D, `fill_index` = 0x0, `fill_tag` = 0x8000001.
- **Memory error:** ack with `mem_err` = 1 on a read. Expect `fill_err` = 1, `fill_data` = 0, `err_count` = 1.
- **Timeout:** `TIMEOUT_CYCLES` = 4, ack never returned. Expect `mem_req` high for exactly 4 cycles, then `fill_valid` with `fill_err` = 1; a late `mem_ack` afterwards is ignored.
- **Reset mid-transaction:** deassert `rst_n` while in REQ. Expect `mem_req` = 0 immediately, no fill beat, and after release `miss_ready` = 1 and both counters = 0.
- **Saturation and stray inputs:** `CNT_WIDTH` = 2 with 5 accepted misses gives `miss_count` = 3. A stray `mem_ack` in IDLE and `miss_valid` held during REQ cause no extra accept.

Source files
------------

// File: rtl/dcache_miss_handler.sv
`default_nettype none
// ============================================================================
// Module   : dcache_miss_handler
// Purpose  : Single-outstanding miss/write-through engine between the dcache
//            and backing memory; returns a one-cycle refill beat.
// Revision : 1.0 - initial release
// ============================================================================
module dcache_miss_handler #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 miss_valid,
  output logic                 miss_ready,
  input  logic [31:0]          miss_addr,
  input  logic                 miss_we,
  input  logic [31:0]          miss_wdata,
  output logic                 fill_valid,
  output logic [3:0]           fill_index,
  output logic [27:0]          fill_tag,
  output logic [31:0]          fill_data,
  output logic                 fill_err,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [31:0]          mem_addr,
  output logic [31:0]          mem_wdata,
  input  logic                 mem_ack,
  input  logic [31:0]          mem_rdata,
  input  logic                 mem_err,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] miss_count,
  output logic [CNT_WIDTH-1:0] err_count
);

  localparam int c_TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_TMO_W-1:0]   c_TMO_LAST = c_TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] c_CNT_MAX  = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 w_accept;
  logic                 w_ack;
  logic                 w_timeout;

  logic [31:0]          r_addr;
  logic                 r_we;
  logic [31:0]          r_wdata;
  logic [c_TMO_W-1:0]   r_tmo;
  logic [31:0]          r_fill_data;
  logic                 r_fill_err;
  logic [CNT_WIDTH-1:0] r_miss_count;
  logic [CNT_WIDTH-1:0] r_err_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // An ack arriving in the final timeout cycle takes priority over the abort.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_ack       = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (miss_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        if (mem_ack) begin
          w_ack       = 1'b1;
          w_state_nxt = ST_RESP;
        end else if (r_tmo == c_TMO_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr       <= '0;
      r_we         <= 1'b0;
      r_wdata      <= '0;
      r_tmo        <= '0;
      r_fill_data  <= '0;
      r_fill_err   <= 1'b0;
      r_miss_count <= '0;
      r_err_count  <= '0;
    end else begin
      if (w_accept) begin
        r_addr  <= miss_addr;
        r_we    <= miss_we;
        r_wdata <= miss_we ? miss_wdata : 32'd0;
        r_tmo   <= '0;
        if (r_miss_count != c_CNT_MAX) r_miss_count <= r_miss_count + CNT_WIDTH'(1);
      end
      if (r_state == ST_REQ && !w_ack && !w_timeout) r_tmo <= r_tmo + c_TMO_W'(1);
      if (w_ack) begin
        r_fill_err  <= mem_err;
        r_fill_data <= mem_err ? 32'd0 : (r_we ? r_wdata : mem_rdata);
      end
      if (w_timeout) begin
        r_fill_err  <= 1'b1;
        r_fill_data <= 32'd0;
      end
      if (r_state == ST_RESP && r_fill_err && r_err_count != c_CNT_MAX)
        r_err_count <= r_err_count + CNT_WIDTH'(1);
    end
  end

  // Bus and fill outputs are forced to zero outside their owning state.
  assign miss_ready = (r_state == ST_IDLE);
  assign busy       = (r_state != ST_IDLE);
  assign mem_req    = (r_state == ST_REQ);
  assign mem_we     = mem_req ? r_we    : 1'b0;
  assign mem_addr   = mem_req ? r_addr  : 32'd0;
  assign mem_wdata  = mem_req ? r_wdata : 32'd0;
  assign fill_valid = (r_state == ST_RESP);
  assign fill_index = fill_valid ? r_addr[3:0]  : 4'd0;
  assign fill_tag   = fill_valid ? r_addr[31:4] : 28'd0;
  assign fill_data  = fill_valid ? r_fill_data  : 32'd0;
  assign fill_err   = fill_valid ? r_fill_err   : 1'b0;
  assign miss_count = r_miss_count;
  assign err_count  = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_dcache_miss_handler.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcache_miss_handler
// Purpose  : Scoreboard bench for dcache_miss_handler (short timeout, 2-bit
//            counters so saturation is reachable).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dcache_miss_handler;

  localparam int c_TMO = 4;
  localparam int c_CW  = 2;
  localparam int c_MAX = (1 << c_CW) - 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            miss_valid = 1'b0;
  logic            miss_ready;
  logic [31:0]     miss_addr = '0;
  logic            miss_we = 1'b0;
  logic [31:0]     miss_wdata = '0;
  logic            fill_valid;
  logic [3:0]      fill_index;
  logic [27:0]     fill_tag;
  logic [31:0]     fill_data;
  logic            fill_err;
  logic            mem_req;
  logic            mem_we;
  logic [31:0]     mem_addr;
  logic [31:0]     mem_wdata;
  logic            mem_ack = 1'b0;
  logic [31:0]     mem_rdata = '0;
  logic            mem_err = 1'b0;
  logic            busy;
  logic [c_CW-1:0] miss_count;
  logic [c_CW-1:0] err_count;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_miss = 0;
  int exp_errc = 0;
  logic [64:0] sb_q[$];

  dcache_miss_handler #(.TIMEOUT_CYCLES(c_TMO), .CNT_WIDTH(c_CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_addr(miss_addr),
    .miss_we(miss_we), .miss_wdata(miss_wdata),
    .fill_valid(fill_valid), .fill_index(fill_index), .fill_tag(fill_tag),
    .fill_data(fill_data), .fill_err(fill_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_err(mem_err),
    .busy(busy), .miss_count(miss_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Fill beats are popped against the expected entries queued at request time.
  always @(negedge clk) begin
    if (rst_n && fill_valid) begin
      if (sb_q.size() == 0) begin
        chk("fill_unexpected", 64'd1, 64'd0);
      end else begin
        logic [64:0] e;
        e = sb_q.pop_front();
        chk("fill_index", {60'd0, fill_index}, {60'd0, e[64:61]});
        chk("fill_tag",   {36'd0, fill_tag},   {36'd0, e[60:33]});
        chk("fill_data",  {32'd0, fill_data},  {32'd0, e[32:1]});
        chk("fill_err",   {63'd0, fill_err},   {63'd0, e[0]});
      end
    end
  end

  task automatic chk_bus(input logic [31:0] addr, input logic we, input logic [31:0] wdata);
    chk("mem_drive", {mem_req, mem_we, mem_addr, mem_wdata}, {1'b1, we, addr, wdata});
  endtask

  // delay < 0 means no ack is ever returned (timeout path).
  task automatic do_req(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                        input int delay, input logic [31:0] rdata, input logic err,
                        input logic hold);
    int n;
    logic        e_err;
    logic [31:0] e_data;
    n = 0;
    while (!miss_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk("ready_wait", {63'd0, miss_ready}, 64'd1);
    miss_valid = 1'b1; miss_addr = addr; miss_we = we; miss_wdata = wdata;
    e_err  = (delay < 0) || err;
    e_data = e_err ? 32'd0 : (we ? wdata : rdata);
    sb_q.push_back({addr[3:0], addr[31:4], e_data, e_err});
    @(posedge clk); #1;
    if (!hold) miss_valid = 1'b0;
    if (exp_miss < c_MAX) exp_miss++;
    chk("miss_count", {62'd0, miss_count}, 64'(exp_miss));
    if (delay >= 0) begin
      for (int k = 0; k < delay; k++) begin
        chk_bus(addr, we, wdata);
        @(posedge clk); #1;
      end
      chk_bus(addr, we, wdata);
      mem_ack = 1'b1; mem_rdata = rdata; mem_err = err;
      @(posedge clk); #1;
      mem_ack = 1'b0; mem_rdata = '0; mem_err = 1'b0; miss_valid = 1'b0;
    end else begin
      n = 0;
      while (mem_req && n < 20) begin @(posedge clk); #1; n++; end
      chk("timeout_len", 64'(n), 64'(c_TMO));
    end
    chk("fill_beat", {63'd0, fill_valid}, 64'd1);
    @(posedge clk); #1;
    if (e_err && exp_errc < c_MAX) exp_errc++;
    chk("err_count", {62'd0, err_count}, 64'(exp_errc));
    chk("ready_after", {62'd0, miss_ready, busy}, 64'd2);
  endtask

  task automatic chk_idle_quiet(input string tag);
    chk(tag, {miss_ready, busy, fill_valid, mem_req, mem_we, mem_wdata},
        {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0});
    chk("counts", {miss_count, err_count}, {c_CW'(exp_miss), c_CW'(exp_errc)});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #12;
    chk_idle_quiet("reset_state");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    do_req(32'h0000_1234, 1'b0, 32'd0,        0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    do_req(32'h8000_0010, 1'b1, 32'hCAFE_F00D, c_TMO - 1, 32'h1234_5678, 1'b0, 1'b1);
    do_req(32'h0000_00A8, 1'b0, 32'd0,        1, 32'h0000_FFFF, 1'b1, 1'b0);
    do_req(32'h4444_5557, 1'b0, 32'd0,       -1, 32'd0,        1'b0, 1'b0);

    // Late/stray ack with nothing outstanding must change nothing.
    mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0; mem_err = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0; mem_rdata = '0; mem_err = 1'b0;
    @(posedge clk); #1;
    chk_idle_quiet("stray_ack");

    do_req(32'h0000_0F0C, 1'b0, 32'd0,        2, 32'h0BAD_F00D, 1'b0, 1'b0);
    do_req(32'h1000_0001, 1'b0, 32'd0,        0, 32'd0,        1'b1, 1'b0);
    do_req(32'h1000_0002, 1'b1, 32'h5555_AAAA, 0, 32'd0,       1'b1, 1'b0);

    // Asynchronous reset while a transaction is in flight.
    miss_valid = 1'b1; miss_addr = 32'h7777_0003; miss_we = 1'b1; miss_wdata = 32'h1111_2222;
    @(posedge clk); #1;
    miss_valid = 1'b0;
    @(posedge clk); #1;
    chk_bus(32'h7777_0003, 1'b1, 32'h1111_2222);
    rst_n = 1'b0;
    #1;
    exp_miss = 0; exp_errc = 0;
    chk_idle_quiet("async_reset");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk_idle_quiet("after_reset");

    do_req(32'hFFFF_FFFF, 1'b0, 32'd0,        1, 32'h89AB_CDEF, 1'b0, 1'b0);

    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
